// File: rtl/aes_stream_ctrl.sv
// Front-end sequencer for an AES core: key load and expansion request, 32-bit stream
// words assembled into 128-bit blocks, one core operation per block, result drained as 32-bit words.
module aes_stream_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         cfg_encdec,
    input  logic         cfg_keylen,

    input  logic         key_wr,
    input  logic [2:0]   key_addr,
    input  logic [31:0]  key_wdata,
    input  logic         key_start,
    output logic         key_busy,
    output logic         key_ok,
    output logic         err_timeout,

    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,

    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,

    output logic         core_init,
    output logic         core_next,
    input  logic         core_ready,
    output logic [255:0] core_key,
    output logic         core_keylen,
    output logic         core_encdec,
    output logic [127:0] core_block,
    input  logic [127:0] core_result,
    input  logic         core_result_valid,

    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        KEY_WAIT = 2'd1,
        CRYPT    = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t         state_q,    state_d;
    logic [1:0]     word_cnt_q, word_cnt_d;
    logic [1:0]     out_cnt_q,  out_cnt_d;
    logic [255:0]   key_q,      key_d;
    logic [127:0]   block_q,    block_d;
    logic [127:0]   out_q,      out_d;
    logic           keylen_q,   keylen_d;
    logic           encdec_q,   encdec_d;
    logic           key_ok_q,   key_ok_d;
    logic           err_q,      err_d;
    logic           init_q,     init_d;
    logic           next_q,     next_d;
    logic           busy_q,     busy_d;
    logic [15:0]    tmo_q,      tmo_d;

    logic           key_cmd_window;
    logic           key_wr_acc;
    logic           key_start_acc;
    logic           s_acc;
    logic           m_acc;
    logic           tmo_expired;

    // Both stream ports use plain valid/ready: a word moves on a rising edge where valid and
    // ready are both high; the sender keeps valid and data stable until that edge.
    // Key commands are only honoured between blocks, and they take the cycle away from the stream.
    assign key_cmd_window = (state_q == IDLE) && (word_cnt_q == 2'd0);
    assign key_wr_acc     = key_cmd_window && key_wr;
    assign key_start_acc  = key_cmd_window && key_start && !key_wr;

    assign s_ready = (state_q == IDLE) && key_ok_q &&
                     !(key_cmd_window && (key_wr || key_start));
    assign s_acc   = s_valid && s_ready;

    assign m_valid = (state_q == DRAIN);
    assign m_data  = out_q[{~out_cnt_q, 5'b0} +: 32];
    assign m_acc   = m_valid && m_ready;

    assign tmo_expired = (tmo_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        out_cnt_d  = out_cnt_q;
        key_d      = key_q;
        block_d    = block_q;
        out_d      = out_q;
        keylen_d   = keylen_q;
        encdec_d   = encdec_q;
        key_ok_d   = key_ok_q;
        err_d      = err_q;
        init_d     = 1'b0;
        next_d     = 1'b0;
        tmo_d      = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (key_wr_acc) begin
                    key_d[{~key_addr, 5'b0} +: 32] = key_wdata;
                    key_ok_d = 1'b0;
                end else if (key_start_acc) begin
                    keylen_d = cfg_keylen;
                    key_ok_d = 1'b0;
                    err_d    = 1'b0;
                    init_d   = 1'b1;
                    tmo_d    = 16'd0;
                    state_d  = KEY_WAIT;
                end else if (s_acc) begin
                    block_d[{~word_cnt_q, 5'b0} +: 32] = s_data;
                    if (word_cnt_q == 2'd0) begin
                        encdec_d = cfg_encdec;
                    end
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        next_d  = 1'b1;
                        tmo_d   = 16'd0;
                        state_d = CRYPT;
                    end
                end
            end

            KEY_WAIT: begin
                if (core_ready) begin
                    key_ok_d = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_expired) begin
                    err_d      = 1'b1;
                    key_ok_d   = 1'b0;
                    word_cnt_d = 2'd0;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            CRYPT: begin
                if (core_result_valid) begin
                    out_d     = core_result;
                    out_cnt_d = 2'd0;
                    state_d   = DRAIN;
                end else if (tmo_expired) begin
                    err_d      = 1'b1;
                    key_ok_d   = 1'b0;
                    word_cnt_d = 2'd0;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            DRAIN: begin
                if (m_acc) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        word_cnt_d = 2'd0;
                        state_d    = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == KEY_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= 2'd0;
            out_cnt_q  <= 2'd0;
            key_q      <= '0;
            block_q    <= '0;
            out_q      <= '0;
            keylen_q   <= 1'b0;
            encdec_q   <= 1'b0;
            key_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
            next_q     <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            out_cnt_q  <= out_cnt_d;
            key_q      <= key_d;
            block_q    <= block_d;
            out_q      <= out_d;
            keylen_q   <= keylen_d;
            encdec_q   <= encdec_d;
            key_ok_q   <= key_ok_d;
            err_q      <= err_d;
            init_q     <= init_d;
            next_q     <= next_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    assign key_busy    = busy_q;
    assign key_ok      = key_ok_q;
    assign err_timeout = err_q;
    assign core_init   = init_q;
    assign core_next   = next_q;
    assign core_key    = key_q;
    assign core_keylen = keylen_q;
    assign core_encdec = encdec_q;
    assign core_block  = block_q;
    assign dbg_state   = state_q;

endmodule
